// File: rtl/dpram_arbiter.sv
// Four-client round-robin arbiter onto a dual-port RAM: up to two grants per cycle,
// with a one-stage tracker per port that routes registered read data back to its client.
module dpram_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [NUM_REQ*DATA_W-1:0] rdata,
  output logic                      ram_we_a,
  output logic [ADDR_W-1:0]         ram_addr_a,
  output logic [DATA_W-1:0]         ram_din_a,
  input  logic [DATA_W-1:0]         ram_dout_a,
  output logic                      ram_we_b,
  output logic [ADDR_W-1:0]         ram_addr_b,
  output logic [DATA_W-1:0]         ram_din_b,
  input  logic [DATA_W-1:0]         ram_dout_b
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [IDX_W-1:0]          idx_c, a_idx, b_idx;
  logic                      a_fnd, b_fnd, b_ok, conflict;
  logic [ADDR_W-1:0]         a_addr, b_addr;
  logic                      trk_a_vld_q, trk_a_vld_d, trk_a_rd_q, trk_a_rd_d;
  logic                      trk_b_vld_q, trk_b_vld_d, trk_b_rd_q, trk_b_rd_d;
  logic [IDX_W-1:0]          trk_a_id_q, trk_a_id_d, trk_b_id_q, trk_b_id_d;
  logic [NUM_REQ*DATA_W-1:0] rdata_q, rdata_d;

  // Walk clients from ptr upward; first requester takes port A, second takes port B.
  always_comb begin
    a_fnd = 1'b0;
    b_fnd = 1'b0;
    a_idx = '0;
    b_idx = '0;
    idx_c = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_c = ptr_q + IDX_W'(k);
      if (req[idx_c] && !rst) begin
        if (!a_fnd) begin
          a_fnd = 1'b1;
          a_idx = idx_c;
        end else if (!b_fnd) begin
          b_fnd = 1'b1;
          b_idx = idx_c;
        end
      end
    end
  end

  assign a_addr   = addr[a_idx*ADDR_W +: ADDR_W];
  assign b_addr   = addr[b_idx*ADDR_W +: ADDR_W];
  assign conflict = (a_addr == b_addr) && (we[a_idx] || we[b_idx]);
  assign b_ok     = b_fnd && !conflict;

  always_comb begin
    gnt = '0;
    if (a_fnd) gnt[a_idx] = 1'b1;
    if (b_ok)  gnt[b_idx] = 1'b1;
  end

  assign ram_we_a   = a_fnd && we[a_idx];
  assign ram_addr_a = a_fnd ? a_addr : '0;
  assign ram_din_a  = a_fnd ? wdata[a_idx*DATA_W +: DATA_W] : '0;
  assign ram_we_b   = b_ok && we[b_idx];
  assign ram_addr_b = b_ok ? b_addr : '0;
  assign ram_din_b  = b_ok ? wdata[b_idx*DATA_W +: DATA_W] : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (b_ok)       ptr_d = b_idx + IDX_W'(1);
    else if (a_fnd) ptr_d = a_idx + IDX_W'(1);
  end

  assign trk_a_vld_d = a_fnd;
  assign trk_a_id_d  = a_idx;
  assign trk_a_rd_d  = !we[a_idx];
  assign trk_b_vld_d = b_ok;
  assign trk_b_id_d  = b_idx;
  assign trk_b_rd_d  = !we[b_idx];

  // RAM data arrives the cycle after the grant; steer it to the owning client's lane.
  always_comb begin
    rvalid  = '0;
    rdata_d = rdata_q;
    if (trk_a_vld_q && trk_a_rd_q) begin
      rvalid[trk_a_id_q]                    = 1'b1;
      rdata_d[trk_a_id_q*DATA_W +: DATA_W] = ram_dout_a;
    end
    if (trk_b_vld_q && trk_b_rd_q) begin
      rvalid[trk_b_id_q]                    = 1'b1;
      rdata_d[trk_b_id_q*DATA_W +: DATA_W] = ram_dout_b;
    end
  end

  assign rdata = rdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      trk_a_vld_q <= 1'b0;
      trk_a_id_q  <= '0;
      trk_a_rd_q  <= 1'b0;
      trk_b_vld_q <= 1'b0;
      trk_b_id_q  <= '0;
      trk_b_rd_q  <= 1'b0;
      rdata_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      trk_a_vld_q <= trk_a_vld_d;
      trk_a_id_q  <= trk_a_id_d;
      trk_a_rd_q  <= trk_a_rd_d;
      trk_b_vld_q <= trk_b_vld_d;
      trk_b_id_q  <= trk_b_id_d;
      trk_b_rd_q  <= trk_b_rd_d;
      rdata_q     <= rdata_d;
    end
  end
endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed bench for dpram_arbiter with a behavioural registered-output dual-port RAM.
module tb_dpram_arbiter;
  logic        clk;
  logic        rst;
  logic [3:0]  req, we, gnt, rvalid;
  logic [31:0] addr, wdata, rdata;
  logic        ram_we_a, ram_we_b;
  logic [7:0]  ram_addr_a, ram_din_a, ram_dout_a;
  logic [7:0]  ram_addr_b, ram_din_b, ram_dout_b;
  logic [7:0]  mem [256];
  int          errors;
  int          checks;

  dpram_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a), .ram_dout_a(ram_dout_a),
    .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_din_b(ram_din_b), .ram_dout_b(ram_dout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory preload: mem[i] = i ^ 0x5A
  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
  end

  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
    ram_dout_a <= mem[ram_addr_a];
    ram_dout_b <= mem[ram_addr_b];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    req = '0; we = '0; addr = '0; wdata = '0;
  endtask

  task automatic set_cl(input int i, input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    req[i] = r;
    we[i]  = w;
    addr[i*8 +: 8]  = a;
    wdata[i*8 +: 8] = d;
  endtask

  task automatic test_reset;
    rst = 1'b1; clr(); tick(); tick();
    for (int i = 0; i < 4; i++) set_cl(i, 1'b1, 1'b0, 8'(i + 1), 8'h00);
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
    checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL rst_rvalid: got %b want 0000", rvalid); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    rst = 1'b0; #1;
    checks++; if (gnt !== 4'b0011) begin errors++; $display("FAIL first_gnt: got %b want 0011", gnt); end
    checks++; if (ram_addr_a !== 8'h01 || ram_addr_b !== 8'h02) begin errors++; $display("FAIL first_addr: got %h/%h want 01/02", ram_addr_a, ram_addr_b); end
    checks++; if (ram_we_a !== 1'b0 || ram_we_b !== 1'b0) begin errors++; $display("FAIL first_we: got %b/%b want 0/0", ram_we_a, ram_we_b); end
    tick();
    checks++; if (gnt !== 4'b1100) begin errors++; $display("FAIL second_gnt: got %b want 1100", gnt); end
    checks++; if (rvalid !== 4'b0011) begin errors++; $display("FAIL second_rvalid: got %b want 0011", rvalid); end
    checks++; if (rdata[7:0] !== 8'h5B || rdata[15:8] !== 8'h58) begin errors++; $display("FAIL second_rdata: got %h/%h want 5b/58", rdata[7:0], rdata[15:8]); end
    checks++; if (ram_addr_a !== 8'h03 || ram_addr_b !== 8'h04) begin errors++; $display("FAIL second_addr: got %h/%h want 03/04", ram_addr_a, ram_addr_b); end
    tick(); clr(); #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL idle_gnt: got %b want 0000", gnt); end
    checks++; if (rvalid !== 4'b1100) begin errors++; $display("FAIL third_rvalid: got %b want 1100", rvalid); end
    checks++; if (rdata[23:16] !== 8'h59 || rdata[31:24] !== 8'h5E) begin errors++; $display("FAIL third_rdata: got %h/%h want 59/5e", rdata[23:16], rdata[31:24]); end
    checks++; if (ram_addr_a !== 8'h00 || ram_din_b !== 8'h00) begin errors++; $display("FAIL idle_port: got %h/%h want 00/00", ram_addr_a, ram_din_b); end
    tick();
    checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL pulse_end: got %b want 0000", rvalid); end
    checks++; if (rdata[7:0] !== 8'h5B) begin errors++; $display("FAIL rdata_hold0: got %h want 5b", rdata[7:0]); end
  endtask

  task automatic test_write_conflict;  // ptr = 0 on entry
    set_cl(0, 1'b1, 1'b1, 8'h10, 8'hAA);
    set_cl(1, 1'b1, 1'b1, 8'h10, 8'h55);
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL ww_gnt1: got %b want 0001", gnt); end
    checks++; if (ram_we_b !== 1'b0 || ram_addr_b !== 8'h00) begin errors++; $display("FAIL ww_portb: got we=%b addr=%h want 0/00", ram_we_b, ram_addr_b); end
    checks++; if (ram_we_a !== 1'b1 || ram_din_a !== 8'hAA) begin errors++; $display("FAIL ww_porta: got we=%b din=%h want 1/aa", ram_we_a, ram_din_a); end
    tick(); set_cl(0, 1'b0, 1'b0, 8'h00, 8'h00); #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL ww_gnt2: got %b want 0010", gnt); end
    checks++; if (ram_din_a !== 8'h55 || ram_addr_a !== 8'h10) begin errors++; $display("FAIL ww_porta2: got din=%h addr=%h want 55/10", ram_din_a, ram_addr_a); end
    checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL write_no_rvalid: got %b want 0000", rvalid); end
    tick(); clr(); set_cl(0, 1'b1, 1'b0, 8'h10, 8'h00); #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL ww_readgnt: got %b want 0001", gnt); end
    tick(); clr(); #1;
    checks++; if (rvalid !== 4'b0001) begin errors++; $display("FAIL ww_rvalid: got %b want 0001", rvalid); end
    checks++; if (rdata[7:0] !== 8'h55) begin errors++; $display("FAIL ww_rdata: got %h want 55", rdata[7:0]); end
    tick();
  endtask

  task automatic test_rw_conflict;  // ptr = 1 on entry
    set_cl(1, 1'b1, 1'b1, 8'h50, 8'h77);
    set_cl(2, 1'b1, 1'b0, 8'h50, 8'h00);
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rw_gnt1: got %b want 0010", gnt); end
    tick(); set_cl(1, 1'b0, 1'b0, 8'h00, 8'h00); #1;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL rw_gnt2: got %b want 0100", gnt); end
    tick(); clr(); #1;
    checks++; if (rvalid !== 4'b0100 || rdata[23:16] !== 8'h77) begin errors++; $display("FAIL rw_read: got rvalid=%b data=%h want 0100/77", rvalid, rdata[23:16]); end
    tick();
  endtask

  task automatic test_write_then_read;  // ptr = 3 on entry
    set_cl(2, 1'b1, 1'b1, 8'h20, 8'h3C); #1;
    checks++; if (gnt !== 4'b0100 || ram_we_a !== 1'b1 || ram_addr_a !== 8'h20) begin errors++; $display("FAIL wr_gnt: got gnt=%b we=%b addr=%h want 0100/1/20", gnt, ram_we_a, ram_addr_a); end
    tick(); clr(); set_cl(3, 1'b1, 1'b0, 8'h20, 8'h00); #1;
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL rd_gnt: got %b want 1000", gnt); end
    checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL wr_no_rvalid: got %b want 0000", rvalid); end
    tick(); clr(); #1;
    checks++; if (rvalid !== 4'b1000 || rdata[31:24] !== 8'h3C) begin errors++; $display("FAIL rd_data: got rvalid=%b data=%h want 1000/3c", rvalid, rdata[31:24]); end
    tick();
    checks++; if (rvalid !== 4'b0000 || rdata[31:24] !== 8'h3C) begin errors++; $display("FAIL rd_hold: got rvalid=%b data=%h want 0000/3c", rvalid, rdata[31:24]); end
  endtask

  task automatic test_back_to_back;  // ptr = 0 on entry
    set_cl(1, 1'b1, 1'b0, 8'h30, 8'h00); #1;
    for (int c = 0; c < 4; c++) begin
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b want 0010", c, gnt); end
      checks++; if (ram_we_b !== 1'b0 || ram_addr_b !== 8'h00 || ram_addr_a !== 8'h30) begin errors++; $display("FAIL b2b_ports[%0d]: got web=%b addrb=%h addra=%h want 0/00/30", c, ram_we_b, ram_addr_b, ram_addr_a); end
      if (c > 0) begin
        checks++; if (rvalid !== 4'b0010 || rdata[15:8] !== 8'h6A) begin errors++; $display("FAIL b2b_read[%0d]: got rvalid=%b data=%h want 0010/6a", c, rvalid, rdata[15:8]); end
      end
      tick();
    end
    clr(); #1;
    checks++; if (rvalid !== 4'b0010) begin errors++; $display("FAIL b2b_last: got %b want 0010", rvalid); end
    tick();
  endtask

  task automatic test_dual_read;  // ptr = 2 on entry
    set_cl(3, 1'b1, 1'b0, 8'h40, 8'h00);
    set_cl(0, 1'b1, 1'b0, 8'h40, 8'h00);
    #1;
    checks++; if (gnt !== 4'b1001) begin errors++; $display("FAIL dual_gnt: got %b want 1001", gnt); end
    checks++; if (ram_addr_a !== 8'h40 || ram_addr_b !== 8'h40) begin errors++; $display("FAIL dual_addr: got %h/%h want 40/40", ram_addr_a, ram_addr_b); end
    tick(); clr(); #1;
    checks++; if (rvalid !== 4'b1001) begin errors++; $display("FAIL dual_rvalid: got %b want 1001", rvalid); end
    checks++; if (rdata[31:24] !== 8'h1A || rdata[7:0] !== 8'h1A) begin errors++; $display("FAIL dual_rdata: got %h/%h want 1a/1a", rdata[31:24], rdata[7:0]); end
    tick();
  endtask

  task automatic test_reset_mid_read;  // ptr = 1 on entry
    set_cl(2, 1'b1, 1'b0, 8'h05, 8'h00); #1;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL mid_gnt: got %b want 0100", gnt); end
    tick(); clr(); #1;
    checks++; if (rvalid !== 4'b0100 || rdata[23:16] !== 8'h5F) begin errors++; $display("FAIL mid_pre: got rvalid=%b data=%h want 0100/5f", rvalid, rdata[23:16]); end
    rst = 1'b1; req = 4'b1111; #1;
    checks++; if (rvalid !== 4'b0000 || rdata !== 32'h0) begin errors++; $display("FAIL mid_rst: got rvalid=%b rdata=%h want 0000/0", rvalid, rdata); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mid_rst_gnt: got %b want 0000", gnt); end
    clr(); rst = 1'b0; tick();
    checks++; if (rvalid !== 4'b0000 || rdata !== 32'h0) begin errors++; $display("FAIL mid_after: got rvalid=%b rdata=%h want 0000/0", rvalid, rdata); end
    set_cl(1, 1'b1, 1'b0, 8'h07, 8'h00); #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL pend_gnt: got %b want 0010", gnt); end
    rst = 1'b1; #1; clr(); rst = 1'b0; tick();
    checks++; if (rvalid !== 4'b0000 || rdata !== 32'h0) begin errors++; $display("FAIL pend_drop: got rvalid=%b rdata=%h want 0000/0", rvalid, rdata); end
    tick();
    checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL pend_late: got %b want 0000", rvalid); end
    for (int i = 0; i < 4; i++) set_cl(i, 1'b1, 1'b0, 8'(i + 8), 8'h00);
    #1;
    checks++; if (gnt !== 4'b0011) begin errors++; $display("FAIL ptr_zero: got %b want 0011", gnt); end
    clr(); tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    clr();
    test_reset();
    test_write_conflict();
    test_rw_conflict();
    test_write_then_read();
    test_back_to_back();
    test_dual_read();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dpram_arbiter.md
DPRAM_ARBITER -- requirements
Module: dpram_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesting clients; fixed at 4 for this release.
REQ-002 Parameter ADDR_W, default 8: RAM address width.
REQ-003 Parameter DATA_W, default 8: RAM data width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req  in  NUM_REQ  per-client request; held high until granted.
REQ-007 we  in  NUM_REQ  per-client write enable (1=write, 0=read); qualified by req.
REQ-008 addr  in  NUM_REQ*ADDR_W  per-client address; client i at bits [i*ADDR_W +: ADDR_W].
REQ-009 wdata  in  NUM_REQ*DATA_W  per-client write data, same packing.
REQ-010 gnt  out  NUM_REQ  per-client grant; combinational, same cycle as req.
REQ-011 rvalid  out  NUM_REQ  per-client read-data-valid pulse, registered.
REQ-012 rdata  out  NUM_REQ*DATA_W  per-client read data, registered, same packing.
REQ-013 ram_we_a / ram_addr_a / ram_din_a  out  1 / ADDR_W / DATA_W  RAM port A controls.
REQ-014 ram_dout_a  in  DATA_W  RAM port A registered read data.
REQ-015 ram_we_b / ram_addr_b / ram_din_b / ram_dout_b: as REQ-013/014 for port B.

Function
REQ-016 Round-robin pointer ptr (2 bits) SHALL name the highest-priority client; search order ptr, ptr+1, ... mod 4.
REQ-017 First requesting client in search order SHALL be granted port A; next requesting client SHALL be granted port B.
REQ-018 Conflict: if A and B candidates use the same address and at least one writes, B grant SHALL be withheld that cycle.
REQ-019 At most two gnt bits SHALL be high per cycle; gnt SHALL be zero when req is zero or rst is high.
REQ-020 Granted port SHALL drive ram_we = client we, ram_addr = client addr, ram_din = client wdata in the grant cycle.
REQ-021 Ungranted port SHALL drive ram_we=0, ram_addr=0, ram_din=0.
REQ-022 Ptr update: any grant -> ptr <= (index of last granted client, B if granted else A) + 1 mod 4; no grant -> unchanged.
REQ-023 One-stage tracking pipeline per port SHALL register {valid, client id, is_read} at each grant.
REQ-024 Read granted in cycle N: rvalid[client] SHALL pulse high for exactly one cycle N+1, with rdata[client] = that port's ram_dout.
REQ-025 Writes SHALL NOT generate rvalid.
REQ-026 rdata[client] SHALL hold its last value until the next read completion for that client.
REQ-027 A client granted in cycle N MAY be granted again in N+1 if req stays high; back-to-back throughput = 2 accesses/cycle.
REQ-028 Both pipeline stages completing for different clients in one cycle SHALL update both rvalid/rdata lanes independently.

Reset
REQ-029 rst high SHALL asynchronously force ptr=0, pipeline valid=0, rvalid=0, rdata=0.
REQ-030 rst asserted mid-read: the pending rvalid SHALL be dropped; no rvalid after rst deasserts until a new grant.
REQ-031 First rising edge after rst deasserts SHALL arbitrate normally from ptr=0.

Verification
REQ-032 After reset, req=4'b1111 all reads, distinct addrs -> gnt=4'b0011; next cycle gnt=4'b1100, rvalid=4'b0011.
REQ-033 Clients 0 and 1 both write addr 0x10 (0xAA, 0x55), ptr=0 -> gnt=4'b0001 only; next cycle gnt=4'b0010; read of 0x10 returns 0x55.
REQ-034 Client 2 writes 0x3C to addr 0x20, then client 3 reads addr 0x20 -> rvalid[3] one cycle after grant, rdata[3]=0x3C.
REQ-035 Client 1 alone requests continuously -> gnt[1] high every cycle, port A used, port B idle (ram_we_b=0).
REQ-036 Read granted, rst pulsed before next edge -> rvalid stays 0, ptr=0, rdata=0 after release.
